// File: rtl/cpu_step_controller_if.sv
// cpu_step_controller_if: CPU-facing signals between the step controller and integrated_cpu
interface cpu_step_controller_if #(
    parameter int PC_W = 11,
    parameter int CPI  = 8
);
    localparam int PH_W = $clog2(CPI);
    logic            cpu_en;
    logic            cpu_load_pc;
    logic [PC_W-1:0] cpu_pc_init;
    logic [PC_W-1:0] cpu_pc;
    logic [PH_W-1:0] phase;
    logic            instr_done;
    modport master (output cpu_en, cpu_load_pc, cpu_pc_init, phase, instr_done, input cpu_pc);
    modport slave  (input cpu_en, cpu_load_pc, cpu_pc_init, phase, instr_done, output cpu_pc);
endinterface

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: run/step sequencer gating the multicycle CPU in fixed CPI-cycle slots
module cpu_step_controller #(
    parameter int PC_W  = 11,
    parameter int CPI   = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_W-1:0]       start_pc,
    input  logic                  go,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      run_count,
    input  logic                  step,
    input  logic                  stop,
    input  logic                  bp_en,
    input  logic [PC_W-1:0]       bp_addr,
    cpu_step_controller_if.master bus,
    output logic [CNT_W-1:0]      retired,
    output logic                  busy,
    output logic                  halted,
    output logic [1:0]            halt_cause
);
    localparam int PH_W = $clog2(CPI);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, HALT} state_t;

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       mode_q;
    logic             stop_q;
    logic             stop_any;
    logic             last;
    logic             step_mode;
    logic             count_mode;
    logic [CNT_W-1:0] ret_inc;
    logic [1:0]       cause;

    // Slot-boundary decisions: pending stop, saturating retire count, halt cause by priority
    always_comb begin
        stop_any   = stop_q | stop;
        last       = bus.phase == PH_W'(CPI - 1);
        step_mode  = mode_q == 2'b01;
        count_mode = mode_q == 2'b10;
        ret_inc    = &retired ? retired : retired + 1'b1;
        cause      = stop_any ? 2'b01 :
                     (count_mode && ret_inc == count_q) ? 2'b10 :
                     (bp_en && bus.cpu_pc == bp_addr) ? 2'b11 : 2'b00;
    end

    // Sequencer FSM; every output is assigned here so all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count_q         <= '0;
            mode_q          <= '0;
            stop_q          <= 1'b0;
            retired         <= '0;
            busy            <= 1'b0;
            halted          <= 1'b0;
            halt_cause      <= '0;
            bus.cpu_en      <= 1'b0;
            bus.cpu_load_pc <= 1'b0;
            bus.cpu_pc_init <= '0;
            bus.phase       <= '0;
            bus.instr_done  <= 1'b0;
        end else begin
            bus.cpu_load_pc <= 1'b0;
            bus.instr_done  <= 1'b0;
            case (state)
                IDLE, HALT: if (go) begin
                    state           <= LOAD;
                    bus.cpu_load_pc <= 1'b1;
                    bus.cpu_pc_init <= start_pc;
                    count_q         <= run_count;
                    mode_q          <= mode;
                    retired         <= '0;
                    halt_cause      <= '0;
                    stop_q          <= 1'b0;
                    busy            <= 1'b1;
                    halted          <= 1'b0;
                end
                LOAD: begin
                    stop_q <= stop_any;
                    if (count_mode && count_q == '0) begin
                        state      <= HALT;
                        busy       <= 1'b0;
                        halted     <= 1'b1;
                        halt_cause <= 2'b10;
                    end else begin
                        state      <= RUN;
                        bus.cpu_en <= 1'b1;
                    end
                end
                RUN: begin
                    stop_q         <= stop_any;
                    bus.phase      <= bus.phase + 1'b1;
                    bus.instr_done <= bus.phase == PH_W'(CPI - 2);
                    if (last) begin
                        retired   <= ret_inc;
                        bus.phase <= '0;
                        if (cause != 2'b00) begin
                            state      <= HALT;
                            bus.cpu_en <= 1'b0;
                            busy       <= 1'b0;
                            halted     <= 1'b1;
                            halt_cause <= cause;
                        end else if (step_mode) begin
                            state      <= PAUSE;
                            bus.cpu_en <= 1'b0;
                        end
                    end
                end
                PAUSE: if (stop_any) begin
                    state      <= HALT;
                    busy       <= 1'b0;
                    halted     <= 1'b1;
                    halt_cause <= 2'b01;
                end else if (step) begin
                    state      <= RUN;
                    bus.cpu_en <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: table, directed and randomized checks of the step controller
module tb_cpu_step_controller;
    localparam int PC_W = 11, CPI = 8, CNT_W = 16, CPI2 = 2, CNT_W2 = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [PC_W-1:0] start_pc = '0, bp_addr = '0, rand_pc = '0;
    logic go = 1'b0, step = 1'b0, stop = 1'b0, bp_en = 1'b0, use_fake = 1'b1;
    logic [1:0] mode = '0;
    logic [CNT_W-1:0] run_count = '0;
    logic [CNT_W-1:0] retired;
    logic busy, halted;
    logic [1:0] halt_cause;
    logic go2 = 1'b0, stop2 = 1'b0;
    logic [1:0] mode2 = '0;
    logic [CNT_W2-1:0] run_count2 = '0;
    logic [CNT_W2-1:0] retired2;
    logic busy2, halted2;
    logic [1:0] halt_cause2;

    cpu_step_controller_if #(.PC_W(PC_W), .CPI(CPI)) bus ();
    cpu_step_controller_if #(.PC_W(PC_W), .CPI(CPI2)) bus2 ();

    // Fake CPU: PC advances by 4 per slot and already shows the next PC in the boundary cycle
    assign bus.cpu_pc = use_fake ? PC_W'(bus.cpu_pc_init + {retired[PC_W-3:0], 2'b00} + PC_W'({bus.instr_done, 2'b00})) : rand_pc;
    assign bus2.cpu_pc = '0;

    cpu_step_controller #(.PC_W(PC_W), .CPI(CPI), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .go(go), .mode(mode),
        .run_count(run_count), .step(step), .stop(stop), .bp_en(bp_en), .bp_addr(bp_addr),
        .bus(bus), .retired(retired), .busy(busy), .halted(halted), .halt_cause(halt_cause));

    cpu_step_controller #(.PC_W(PC_W), .CPI(CPI2), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_pc('0), .go(go2), .mode(mode2),
        .run_count(run_count2), .step(1'b0), .stop(stop2), .bp_en(1'b0), .bp_addr('0),
        .bus(bus2), .retired(retired2), .busy(busy2), .halted(halted2), .halt_cause(halt_cause2));

    always #5 clk = ~clk;

    int checks = 0, passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.instr_done && n < 100) begin tick(); n++; end
        check(name, bus.instr_done, 1);
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 300) begin tick(); n++; end
        check(name, halted, 1);
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({bus.cpu_load_pc, bus.cpu_en, bus.phase, bus.instr_done, busy, halted,
                    halt_cause, retired, bus.cpu_pc_init});
    endfunction

    // Reference model: activity flags plus elapsed cycles in the current slot
    bit m_load, m_run, m_pause, m_halt, m_stop;
    int m_ph, m_ret, m_cnt;
    bit [1:0] m_mode, m_cause;
    logic [PC_W-1:0] m_pc;

    task automatic model_reset();
        {m_load, m_run, m_pause, m_halt, m_stop} = '0;
        m_ph = 0; m_ret = 0; m_cnt = 0; m_mode = 0; m_cause = 0; m_pc = '0;
    endtask

    task automatic model_halt(input bit [1:0] c);
        m_run = 0; m_pause = 0; m_halt = 1; m_cause = c;
    endtask

    task automatic model_step();
        bit pend;
        pend = m_stop | stop;
        if (m_load) begin
            m_load = 0; m_stop = pend;
            if (m_mode == 2 && m_cnt == 0) model_halt(2);
            else begin m_run = 1; m_ph = 0; end
        end else if (m_run) begin
            m_stop = pend;
            if (m_ph < CPI - 1) m_ph++;
            else begin
                m_ph = 0;
                if (m_ret < (1 << CNT_W) - 1) m_ret++;
                if (pend) model_halt(1);
                else if (m_mode == 2 && m_ret == m_cnt) model_halt(2);
                else if (bp_en && rand_pc == bp_addr) model_halt(3);
                else if (m_mode == 1) begin m_run = 0; m_pause = 1; end
            end
        end else if (m_pause) begin
            if (pend) model_halt(1);
            else if (step) begin m_pause = 0; m_run = 1; m_ph = 0; end
        end else if (go) begin
            m_load = 1; m_halt = 0; m_pc = start_pc; m_cnt = int'(run_count);
            m_mode = mode; m_ret = 0; m_cause = 0; m_stop = 0;
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [2:0] ph;
        ph = m_run ? 3'(m_ph) : 3'd0;
        return 64'({m_load, m_run, ph, (m_run && m_ph == CPI - 1), (m_load | m_run | m_pause),
                    m_halt, m_cause, 16'(m_ret), m_pc});
    endfunction

    typedef struct {
        logic [1:0] mode;
        int cnt, pc;
        bit bpe;
        int bpa, stop_slot, exp_ret, exp_cause, exp_en;
    } vec_t;

    task automatic run_case(input vec_t v, input int idx);
        int en = 0;
        bit done = 0;
        mode = v.mode; run_count = CNT_W'(v.cnt); start_pc = PC_W'(v.pc);
        bp_en = v.bpe; bp_addr = PC_W'(v.bpa);
        go = 1; tick(); go = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            if (bus.cpu_en) en++;
            stop = v.stop_slot > 0 && int'(retired) == v.stop_slot - 1 && bus.phase == 3 && bus.cpu_en;
            if (halted) done = 1;
            else tick();
        end
        stop = 0;
        check($sformatf("case%0d halted", idx), done, 1);
        check($sformatf("case%0d retired", idx), retired, v.exp_ret);
        check($sformatf("case%0d cause", idx), halt_cause, v.exp_cause);
        check($sformatf("case%0d en_cycles", idx), en, v.exp_en);
    endtask

    initial begin
        vec_t tbl [8];
        int n, k, cnt, first, second;
        tbl[0] = '{2'd0, 0, 0,     1'b0, 0,     16, 16, 1, 128};
        tbl[1] = '{2'd2, 5, 0,     1'b0, 0,     0,  5,  2, 40};
        tbl[2] = '{2'd2, 0, 0,     1'b0, 0,     0,  0,  2, 0};
        tbl[3] = '{2'd0, 0, 0,     1'b1, 12,    0,  3,  3, 24};
        tbl[4] = '{2'd0, 0, 0,     1'b1, 12,    3,  3,  1, 24};
        tbl[5] = '{2'd3, 3, 0,     1'b0, 0,     4,  4,  1, 32};
        tbl[6] = '{2'd2, 1, 0,     1'b1, 4,     0,  1,  2, 8};
        tbl[7] = '{2'd0, 0, 'h100, 1'b1, 'h10C, 0,  3,  3, 24};

        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_vec(), 0);
        check("reset2", {busy2, halted2, retired2, halt_cause2, bus2.cpu_en, bus2.phase}, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 8; i++) run_case(tbl[i], i);

        // Free-run timing from go
        mode = 0; start_pc = 0; bp_en = 0;
        go = 1; tick(); go = 0;
        check("go_load", {bus.cpu_load_pc, bus.cpu_en, busy}, 3'b101);
        tick();
        check("go_en", {bus.cpu_load_pc, bus.cpu_en, bus.phase}, {2'b01, 3'd0});
        n = 2;
        while (!bus.instr_done && n < 50) begin tick(); n++; end
        check("first_done_latency", n, 9);
        tick();
        stop = 1; tick(); stop = 0;
        wait_done("free_done2");
        tick();
        check("halt_entry", {halted, bus.cpu_en}, 2'b10);
        check("free_stop", {halt_cause, retired}, {2'b01, 16'd2});

        // Run-count zero halts two cycles after go
        mode = 2; run_count = 0;
        go = 1; tick(); go = 0;
        check("cnt0_load", {halted, bus.cpu_load_pc}, 2'b01);
        tick();
        check("cnt0_halt", {halted, halt_cause, retired}, {1'b1, 2'b10, 16'd0});

        // Single step: three slots, step during RUN ignored, stop+step in PAUSE halts
        mode = 1;
        go = 1; tick(); go = 0; tick();
        for (int s = 1; s <= 3; s++) begin
            cnt = 0;
            while (bus.cpu_en && cnt < 50) begin cnt++; step = cnt == 3; tick(); end
            step = 0;
            check($sformatf("step%0d slot_len", s), cnt, CPI);
            check($sformatf("step%0d pause", s), {busy, halted, bus.cpu_en, bus.phase, retired}, {6'b100000, 16'(s)});
            tick(); tick();
            check($sformatf("step%0d hold", s), {busy, bus.cpu_en}, 2'b10);
            if (s < 3) begin
                step = 1; tick(); step = 0;
            end else begin
                stop = 1; step = 1; tick(); stop = 0; step = 0;
                check("step_stop", {halted, halt_cause, retired, bus.cpu_en}, {1'b1, 2'b01, 16'd3, 1'b0});
            end
        end

        // Asynchronous reset mid-slot, then restart from a new PC
        mode = 0;
        go = 1; tick(); go = 0;
        n = 0;
        while (!(retired == 2 && bus.phase == 4) && n < 100) begin tick(); n++; end
        check("rst_reach", n < 100, 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid", dut_vec(), 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        start_pc = 'h40;
        go = 1; tick(); go = 0;
        check("rst_regone", {bus.cpu_load_pc, retired, bus.cpu_pc_init}, {1'b1, 16'd0, 11'h40});
        wait_done("rst_done");
        tick();
        check("rst_retired", retired, 1);
        stop = 1; tick(); stop = 0;
        wait_halt("rst_halt");

        // CPI=2, 4-bit counter instance: saturation and slot length
        mode2 = 0; run_count2 = 15;
        go2 = 1; tick(); go2 = 0;
        n = 0; k = 0; first = -1; second = -1;
        while (k < 20 && n < 200) begin
            if (bus2.instr_done) begin
                if (k == 0) first = n;
                if (k == 1) second = n;
                k++;
            end
            tick(); n++;
        end
        check("cpi2_first", first, 2);
        check("cpi2_period", second - first, 2);
        check("cpi2_sat", retired2, 15);
        stop2 = 1; tick(); stop2 = 0;
        n = 0;
        while (!halted2 && n < 20) begin tick(); n++; end
        check("cpi2_stop", {halted2, halt_cause2, retired2}, {1'b1, 2'b01, 4'd15});
        mode2 = 2;
        go2 = 1; tick(); go2 = 0;
        n = 0; cnt = 0;
        while (!halted2 && n < 100) begin if (bus2.cpu_en) cnt++; tick(); n++; end
        check("cpi2_count", {halted2, halt_cause2, retired2}, {1'b1, 2'b10, 4'd15});
        check("cpi2_en", cnt, 30);

        // Randomized run against the reference model
        use_fake = 0; bp_addr = 8;
        {go, step, stop, bp_en} = '0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            check("rand", dut_vec(), model_vec());
            go = $urandom_range(0, 15) == 0;
            mode = 2'($urandom_range(0, 3));
            run_count = CNT_W'($urandom_range(0, 4));
            start_pc = PC_W'($urandom);
            step = $urandom_range(0, 5) == 0;
            stop = $urandom_range(0, 79) == 0;
            bp_en = 1'($urandom_range(0, 1));
            rand_pc = PC_W'(4 * $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
